debug_slave_cmd_queue: RTL and testbench

- System-clock-side command receiver for the CPU JTAG debug slave; successor to the fixed 38-bit, 2-bit-IR, unbuffered sysclk capture stage.
- Synchronises update-IR and update-DR toggle events from the TCK domain and captures the shifted data register with the active instruction.
- Queues captured commands in a FIFO of depth FIFO_DEPTH and presents them through a valid/ready interface, with one-hot take_action / take_no_action strobes.

---
 rtl/debug_slave_cmd_queue_if.sv | 33 +++
 rtl/debug_slave_cmd_queue.sv | 145 ++++++++++++++
 tb/tb_debug_slave_cmd_queue.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/debug_slave_cmd_queue_if.sv
// Consumer-side command bus of the JTAG debug slave command queue.
// The queue drives the head entry and the per-pop strobes; the consumer drives cmd_ready.
interface debug_slave_cmd_queue_if #(
    parameter int DATA_W = 38,
    parameter int IR_W   = 2
);
    localparam int NUM_IR = 2 ** IR_W;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] jdo;
    logic [IR_W-1:0]   cmd_ir;
    logic [NUM_IR-1:0] take_action;
    logic [NUM_IR-1:0] take_no_action;

    modport master (
        output cmd_valid,
        output jdo,
        output cmd_ir,
        output take_action,
        output take_no_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  jdo,
        input  cmd_ir,
        input  take_action,
        input  take_no_action,
        output cmd_ready
    );
endinterface

// File: rtl/debug_slave_cmd_queue.sv
// System-clock receiver for JTAG debug commands: synchronises the TCK-domain update toggles,
// captures {instruction, data register} on update-DR and queues them for a valid/ready consumer.
module debug_slave_cmd_queue #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACT_BIT     = 34
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               uir_tgl,
    input  logic                               udr_tgl,
    input  logic [IR_W-1:0]                    ir_in,
    input  logic [DATA_W-1:0]                  sr,
    debug_slave_cmd_queue_if.master            cmd,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill_level,
    output logic                               overrun,
    input  logic                               overrun_clr
);
    localparam int NUM_IR  = 2 ** IR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = IR_W + DATA_W;
    localparam int ARM_W   = $clog2(SYNC_STAGES + 2);

    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
    logic                   uir_prev_q, uir_prev_d;
    logic                   udr_prev_q, udr_prev_d;
    logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
    logic [IR_W-1:0]        ir_reg_q, ir_reg_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ENTRY_W-1:0]     last_q, last_d;
    logic                   overrun_q, overrun_d;
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];

    logic                   armed;
    logic                   uir_evt;
    logic                   udr_evt;
    logic                   empty;
    logic                   full;
    logic                   pop;
    logic                   push_ok;
    logic                   push_drop;
    logic [ENTRY_W-1:0]     head;
    logic [ENTRY_W-1:0]     head_out;
    logic [NUM_IR-1:0]      head_onehot;

    always_comb begin
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], uir_tgl};
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], udr_tgl};
        uir_prev_d = uir_sync_q[SYNC_STAGES-1];
        udr_prev_d = udr_sync_q[SYNC_STAGES-1];

        // prev keeps tracking the synchroniser while disarmed, so a level already
        // present at reset release is absorbed instead of becoming an event
        armed     = (arm_cnt_q == ARM_LAST);
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
        uir_evt   = armed && (uir_sync_q[SYNC_STAGES-1] ^ uir_prev_q);
        udr_evt   = armed && (udr_sync_q[SYNC_STAGES-1] ^ udr_prev_q);

        // a push captures the instruction held before any same-cycle update-IR
        ir_reg_d = uir_evt ? ir_in : ir_reg_q;

        empty     = (count_q == '0);
        full      = (count_q == CNT_FULL);
        head      = mem_q[rd_ptr_q];
        pop       = !empty && cmd.cmd_ready;
        push_ok   = udr_evt && (!full || pop);
        push_drop = udr_evt && full && !pop;

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        last_d = pop ? head : last_q;

        overrun_d = overrun_q;
        if (push_drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            uir_prev_q <= 1'b0;
            udr_prev_q <= 1'b0;
            arm_cnt_q  <= '0;
            ir_reg_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            uir_sync_q <= uir_sync_d;
            udr_sync_q <= udr_sync_d;
            uir_prev_q <= uir_prev_d;
            udr_prev_q <= udr_prev_d;
            arm_cnt_q  <= arm_cnt_d;
            ir_reg_q   <= ir_reg_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_q     <= last_d;
            overrun_q  <= overrun_d;
        end
    end

    // storage needs no reset: only slots between rd_ptr and wr_ptr are ever observed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {ir_reg_q, sr};
        end
    end

    always_comb begin
        head_out    = empty ? last_q : head;
        head_onehot = NUM_IR'(1) << head[ENTRY_W-1 -: IR_W];
    end

    assign cmd.cmd_valid      = !empty;
    assign cmd.jdo            = head_out[DATA_W-1:0];
    assign cmd.cmd_ir         = head_out[ENTRY_W-1 -: IR_W];
    assign cmd.take_action    = (pop && head[ACT_BIT])  ? head_onehot : '0;
    assign cmd.take_no_action = (pop && !head[ACT_BIT]) ? head_onehot : '0;
    assign fill_level         = count_q;
    assign overrun            = overrun_q;
endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// Directed bench for debug_slave_cmd_queue with hand-computed expectations.
module tb_debug_slave_cmd_queue;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        uir_tgl = 1'b0;
    logic        udr_tgl = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic [2:0]  fill_level;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    debug_slave_cmd_queue_if #(.DATA_W(38), .IR_W(2)) cmd_if ();

    debug_slave_cmd_queue #(
        .DATA_W(38), .IR_W(2), .SYNC_STAGES(2), .FIFO_DEPTH(4), .ACT_BIT(34)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .uir_tgl     (uir_tgl),
        .udr_tgl     (udr_tgl),
        .ir_in       (ir_in),
        .sr          (sr),
        .cmd         (cmd_if.master),
        .fill_level  (fill_level),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic uir_send(input logic [1:0] ir);
        ir_in   = ir;
        uir_tgl = ~uir_tgl;
        tick(4);
    endtask

    task automatic udr_send(input logic [37:0] d);
        sr      = d;
        udr_tgl = ~udr_tgl;
        tick(4);
    endtask

    task automatic pop_check(input string tag, input logic [37:0] d, input logic [1:0] ir, input bit act);
        logic [3:0] oh;
        oh = 4'b0001 << ir;
        cmd_if.cmd_ready = 1'b1;
        #1;
        check({tag, "_vld"}, cmd_if.cmd_valid, 1);
        check({tag, "_jdo"}, cmd_if.jdo, d);
        check({tag, "_ir"}, cmd_if.cmd_ir, ir);
        check({tag, "_ta"}, cmd_if.take_action, act ? oh : 4'b0000);
        check({tag, "_tna"}, cmd_if.take_no_action, act ? 4'b0000 : oh);
        @(negedge clk);
        cmd_if.cmd_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;
        cmd_if.cmd_ready = 1'b0;

        // reset state
        tick(3);
        check("rst_vld", cmd_if.cmd_valid, 0);
        check("rst_fill", fill_level, 0);
        check("rst_ovr", overrun, 0);
        check("rst_jdo", cmd_if.jdo, 0);
        check("rst_ta", cmd_if.take_action, 0);
        check("rst_tna", cmd_if.take_no_action, 0);
        reset_n = 1'b1;
        tick(4);

        // basic capture, latency, strobes, head hold
        uir_send(2'd2);
        sr      = 38'h1_2345_6789;
        udr_tgl = ~udr_tgl;
        tick(2);
        check("lat_e2_vld", cmd_if.cmd_valid, 0);
        tick(1);
        check("lat_e3_vld", cmd_if.cmd_valid, 1);
        check("t1_fill", fill_level, 1);
        tick(1);
        pop_check("t1_noact", 38'h1_2345_6789, 2'd2, 1'b0);
        cmd_if.cmd_ready = 1'b1;
        #1;
        check("t1_empty_vld", cmd_if.cmd_valid, 0);
        check("t1_hold_jdo", cmd_if.jdo, 38'h1_2345_6789);
        check("t1_hold_ir", cmd_if.cmd_ir, 2);
        check("t1_empty_ta", cmd_if.take_action, 0);
        check("t1_empty_tna", cmd_if.take_no_action, 0);
        tick(1);
        check("t1_empty_fill", fill_level, 0);
        cmd_if.cmd_ready = 1'b0;
        udr_send(38'h5_2345_6789);
        pop_check("t1_act", 38'h5_2345_6789, 2'd2, 1'b1);

        // fill past capacity without popping
        for (int k = 0; k < 4; k++) udr_send(38'h10 + 38'(k));
        check("t2_fill4", fill_level, 4);
        check("t2_ovr0", overrun, 0);
        udr_send(38'h14);
        check("t2_fill5", fill_level, 4);
        check("t2_ovr1", overrun, 1);
        for (int k = 0; k < 4; k++) pop_check("t2_pop", 38'h10 + 38'(k), 2'd2, 1'b0);
        check("t2_drained", cmd_if.cmd_valid, 0);
        check("t2_ovr_sticky", overrun, 1);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        check("t2_ovr_clr", overrun, 0);

        // push while full coinciding with a pop
        for (int k = 0; k < 4; k++) udr_send(38'h4_0000_0020 + 38'(k));
        sr      = 38'h24;
        udr_tgl = ~udr_tgl;
        tick(2);
        cmd_if.cmd_ready = 1'b1;
        #1;
        check("t3_pop_ta", cmd_if.take_action, 4'b0100);
        tick(1);
        cmd_if.cmd_ready = 1'b0;
        check("t3_fill", fill_level, 4);
        check("t3_ovr", overrun, 0);
        tick(1);
        for (int k = 1; k < 4; k++) pop_check("t3_pop", 38'h4_0000_0020 + 38'(k), 2'd2, 1'b1);
        pop_check("t3_last", 38'h24, 2'd2, 1'b0);

        // mid-operation reset with update-DR toggle held high through release
        udr_send(38'h30);
        udr_send(38'h31);
        check("t4_pre_fill", fill_level, 2);
        reset_n = 1'b0;
        udr_tgl = 1'b1;
        tick(2);
        check("t4_flush_fill", fill_level, 0);
        check("t4_flush_jdo", cmd_if.jdo, 0);
        reset_n    = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (cmd_if.cmd_valid) seen_valid = 1'b1;
        end
        check("t4_no_evt", seen_valid, 0);

        // coincident update-IR and update-DR
        uir_send(2'd1);
        ir_in   = 2'd3;
        sr      = 38'h0_AAAA_5555;
        uir_tgl = ~uir_tgl;
        udr_tgl = ~udr_tgl;
        tick(4);
        udr_send(38'h4_5555_AAAA);
        pop_check("t5_old_ir", 38'h0_AAAA_5555, 2'd1, 1'b0);
        pop_check("t5_new_ir", 38'h4_5555_AAAA, 2'd3, 1'b1);

        // overrun set wins over a same-cycle clear
        check("t6_ovr_pre", overrun, 0);
        for (int k = 0; k < 4; k++) udr_send(38'h40 + 38'(k));
        sr      = 38'h44;
        udr_tgl = ~udr_tgl;
        tick(2);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        check("t6_set_wins", overrun, 1);
        check("t6_fill", fill_level, 4);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        check("t6_clr", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
